// File: rtl/sync_filter_edge_pkg.sv
// sync_filter_edge_pkg
//   Shared constants and helpers for the multi-channel synchroniser/filter.
//   No ports; imported by sync_filter_channel and sync_filter_edge.
package sync_filter_edge_pkg;

  // Shortest chain that still gives a metastability settling stage.
  localparam int MIN_STAGES        = 2;
  // Smallest filter length (1 means a plain synchroniser).
  localparam int MIN_FILTER_CYCLES = 1;

  // Width of the stability counter; at least one bit even when the filter
  // is disabled so the counter declaration stays legal.
  function automatic int cnt_width(input int filter_cycles);
    if (filter_cycles <= 2) begin
      return 1;
    end else begin
      return $clog2(filter_cycles);
    end
  endfunction

endpackage

// File: rtl/sync_filter_channel.sv
// sync_filter_channel
//   One channel: STAGES-deep synchroniser chain, consecutive-cycle glitch
//   filter and registered rise/fall pulse generation.
//   Ports:
//     clk_i    in   clock
//     rst_i    in   synchronous active-high reset
//     serial_i in   asynchronous level input
//     serial_o out  synchronised, filtered level (flop)
//     rise_o   out  one-cycle pulse on serial_o 0->1 (flop)
//     fall_o   out  one-cycle pulse on serial_o 1->0 (flop)
module sync_filter_channel
  import sync_filter_edge_pkg::*;
#(
  parameter int   STAGES        = 2,
  parameter int   FILTER_CYCLES = 1,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic serial_i,
  output logic serial_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int             CNT_W   = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("sync_filter_channel: STAGES must be at least 2");
  end
  if (FILTER_CYCLES < MIN_FILTER_CYCLES) begin : g_bad_filter
    $error("sync_filter_channel: FILTER_CYCLES must be at least 1");
  end

  logic [STAGES-1:0] chain_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              level_r;
  logic              rise_r;
  logic              fall_r;

  logic              sync_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              level_nxt_s;
  logic              rise_nxt_s;
  logic              fall_nxt_s;

  assign sync_s = chain_r[STAGES-1];

  // Synchroniser shift chain: bit 0 captures the raw input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_r <= {STAGES{RESET_VALUE}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], serial_i};
    end
  end

  // Filter decision: the counter only advances while the synced level
  // disagrees with the output, and the >= test caps it at CNT_MAX so it
  // can never wrap even for a non-power-of-two filter length.
  always_comb begin
    cnt_nxt_s   = {CNT_W{1'b0}};
    level_nxt_s = level_r;
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    if (sync_s == level_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r >= CNT_MAX) begin
      level_nxt_s = sync_s;
      rise_nxt_s  = sync_s;
      fall_nxt_s  = ~sync_s;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Filter state and edge pulses; reset clears the partial count and
  // leaves both pulses low so deassertion never produces an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r   <= {CNT_W{1'b0}};
      level_r <= RESET_VALUE;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      level_r <= level_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
    end
  end

  assign serial_o = level_r;
  assign rise_o   = rise_r;
  assign fall_o   = fall_r;

endmodule

// File: rtl/sync_filter_edge.sv
// sync_filter_edge
//   Multi-channel synchroniser with per-channel glitch filter and
//   registered edge pulses. Every channel is independent.
//   Ports:
//     clk_i    in   clock
//     rst_i    in   synchronous active-high reset
//     serial_i in   [WIDTH] asynchronous level inputs
//     serial_o out  [WIDTH] synchronised, filtered levels
//     rise_o   out  [WIDTH] one-cycle pulse per channel on 0->1
//     fall_o   out  [WIDTH] one-cycle pulse per channel on 1->0
module sync_filter_edge
  import sync_filter_edge_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] serial_i,
  output logic [WIDTH-1:0] serial_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("sync_filter_edge: STAGES must be at least 2");
  end
  if (FILTER_CYCLES < MIN_FILTER_CYCLES) begin : g_bad_filter
    $error("sync_filter_edge: FILTER_CYCLES must be at least 1");
  end

  for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
    sync_filter_channel #(
      .STAGES        (STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_VALUE   (RESET_VALUE[ch])
    ) u_channel (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .serial_i (serial_i[ch]),
      .serial_o (serial_o[ch]),
      .rise_o   (rise_o[ch]),
      .fall_o   (fall_o[ch])
    );
  end

endmodule

// File: tb/tb_sync_filter_edge.sv
// tb_sync_filter_edge
//   Two instances: A (WIDTH=4, STAGES=2, FILTER=1, RESET_VALUE=4'b0101) and
//   B (WIDTH=8, STAGES=3, FILTER=4, RESET_VALUE=8'h00). A window-based
//   reference model predicts every output each cycle.
module tb_sync_filter_edge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [3:0] in_a, out_a, rise_a, fall_a;
  logic [7:0] in_b, out_b, rise_b, fall_b;

  sync_filter_edge #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(1), .RESET_VALUE(4'b0101)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .serial_i(in_a),
    .serial_o(out_a), .rise_o(rise_a), .fall_o(fall_a));

  sync_filter_edge #(.WIDTH(8), .STAGES(3), .FILTER_CYCLES(4), .RESET_VALUE(8'h00)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .serial_i(in_b),
    .serial_o(out_b), .rise_o(rise_b), .fall_o(fall_b));

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: synced value = input sampled STAGES edges earlier; the
  // output takes the synced level once the last FILTER synced samples since
  // reset all differ from the current output.
  int         st  [2] = '{2, 3};
  int         fl  [2] = '{1, 4};
  logic [7:0] rv  [2] = '{8'h05, 8'h00};
  logic [7:0] msk [2] = '{8'h0F, 8'hFF};
  logic [7:0] hist[2][8];
  logic [7:0] win [2][8];
  int         wn  [2];
  logic [7:0] m_out[2], m_rise[2], m_fall[2];

  task automatic model_step(input int m, input logic rst, input logic [7:0] din);
    logic [7:0] s;
    logic [7:0] nxt;
    bit         all_dev;
    if (rst) begin
      for (int k = 0; k < 8; k++) hist[m][k] = rv[m];
      wn[m] = 0;
      m_out[m] = rv[m];
      m_rise[m] = 8'h00;
      m_fall[m] = 8'h00;
      return;
    end
    s = hist[m][st[m]-1];
    for (int k = st[m]-1; k > 0; k--) hist[m][k] = hist[m][k-1];
    hist[m][0] = din & msk[m];
    for (int k = fl[m]-1; k > 0; k--) win[m][k] = win[m][k-1];
    win[m][0] = s;
    if (wn[m] < fl[m]) wn[m]++;
    nxt = m_out[m];
    for (int b = 0; b < 8; b++) begin
      if (wn[m] == fl[m]) begin
        all_dev = 1'b1;
        for (int k = 0; k < fl[m]; k++) if (win[m][k][b] == m_out[m][b]) all_dev = 1'b0;
        if (all_dev) nxt[b] = s[b];
      end
    end
    nxt       = nxt & msk[m];
    m_rise[m] = nxt & ~m_out[m];
    m_fall[m] = ~nxt & m_out[m] & msk[m];
    m_out[m]  = nxt;
  endtask

  // Advance model and DUTs by one edge; outputs are then sampled 1 ns later.
  task automatic tick();
    model_step(0, rst_a, {4'h0, in_a});
    model_step(1, rst_b, in_b);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    in_a = 4'($urandom); in_b = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({out_a, rise_a, fall_a} !== {4'b0101, 4'h0, 4'h0}) $display("FAIL reset_a got out=%h rise=%h fall=%h want out=5 rise=0 fall=0", out_a, rise_a, fall_a);
      else n_pass++;
      n_total++;
      if ({out_b, rise_b, fall_b} !== {8'h00, 8'h00, 8'h00}) $display("FAIL reset_b got out=%h rise=%h fall=%h want 00/00/00", out_b, rise_b, fall_b);
      else n_pass++;
    end
    in_a = 4'b0101; in_b = 8'h00;
    rst_a = 1'b0; rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++;
      if ({out_a, rise_a, fall_a} !== {4'b0101, 4'h0, 4'h0}) $display("FAIL release_a cyc %0d got out=%h rise=%h fall=%h want 5/0/0", i, out_a, rise_a, fall_a);
      else n_pass++;
      n_total++;
      if ({out_b, rise_b, fall_b} !== {8'h00, 8'h00, 8'h00}) $display("FAIL release_b cyc %0d got out=%h rise=%h fall=%h want 00/00/00", i, out_b, rise_b, fall_b);
      else n_pass++;
    end
  endtask

  task automatic test_latency();
    in_b[0] = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      tick();
      n_total++;
      if (out_b[0] !== (i >= 6) || rise_b[0] !== (i == 6))
        $display("FAIL latency E0+%0d got out0=%b rise0=%b want %b/%b", i, out_b[0], rise_b[0], (i >= 6), (i == 6));
      else n_pass++;
    end
    in_b[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if ({out_b, rise_b, fall_b} !== {m_out[1], m_rise[1], m_fall[1]})
        $display("FAIL latency_fall cyc %0d got %h/%h/%h want %h/%h/%h", i, out_b, rise_b, fall_b, m_out[1], m_rise[1], m_fall[1]);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int rise_at, fall_at, n_r, n_f;
    in_b[1] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) in_b[1] = 1'b0;
      tick();
      n_total++;
      if (out_b[1] !== 1'b0 || rise_b[1] !== 1'b0 || fall_b[1] !== 1'b0)
        $display("FAIL glitch cyc %0d got out1=%b rise1=%b fall1=%b want 0/0/0", i, out_b[1], rise_b[1], fall_b[1]);
      else n_pass++;
    end
    rise_at = -1; fall_at = -1; n_r = 0; n_f = 0;
    in_b[1] = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 4) in_b[1] = 1'b0;
      tick();
      if (rise_b[1] === 1'b1) begin n_r++; rise_at = i; end
      if (fall_b[1] === 1'b1) begin n_f++; fall_at = i; end
      n_total++;
      if ({out_b, rise_b, fall_b} !== {m_out[1], m_rise[1], m_fall[1]})
        $display("FAIL pulse4 cyc %0d got %h/%h/%h want %h/%h/%h", i, out_b, rise_b, fall_b, m_out[1], m_rise[1], m_fall[1]);
      else n_pass++;
    end
    n_total++;
    if (n_r !== 1 || n_f !== 1 || rise_at !== 6 || fall_at !== 10)
      $display("FAIL pulse4_edges got rises=%0d falls=%0d rise_at=%0d fall_at=%0d want 1/1/6/10", n_r, n_f, rise_at, fall_at);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic cap[$];
    for (int i = 0; i < 20; i++) begin
      in_a[2] = ~in_a[2];
      cap.push_back(in_a[2]);
      tick();
      if (i >= 2) begin
        n_total++;
        if (out_a[2] !== cap[i-2] || (rise_a[2] | fall_a[2]) !== 1'b1 || (rise_a[2] & fall_a[2]) !== 1'b0 || rise_a[2] !== out_a[2])
          $display("FAIL toggle cyc %0d got out2=%b rise2=%b fall2=%b want out2=%b one pulse", i, out_a[2], rise_a[2], fall_a[2], cap[i-2]);
        else n_pass++;
      end
      n_total++;
      if ({out_a, rise_a, fall_a} !== {m_out[0][3:0], m_rise[0][3:0], m_fall[0][3:0]})
        $display("FAIL toggle_model cyc %0d got %h/%h/%h want %h/%h/%h", i, out_a, rise_a, fall_a, m_out[0][3:0], m_rise[0][3:0], m_fall[0][3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_filter();
    in_b[3] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst_b = 1'b1;
    tick();
    n_total++;
    if (out_b[3] !== 1'b0 || rise_b[3] !== 1'b0) $display("FAIL midrst got out3=%b rise3=%b want 0/0", out_b[3], rise_b[3]);
    else n_pass++;
    rst_b = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      tick();
      n_total++;
      if (out_b[3] !== (j >= 6) || rise_b[3] !== (j == 6))
        $display("FAIL midrst_after cyc %0d got out3=%b rise3=%b want %b/%b", j, out_b[3], rise_b[3], (j >= 6), (j == 6));
      else n_pass++;
    end
    in_b = 8'h00;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_all_rise();
    in_b = 8'hFF;
    for (int i = 0; i <= 8; i++) begin
      tick();
      n_total++;
      if (out_b !== ((i >= 6) ? 8'hFF : 8'h00) || rise_b !== ((i == 6) ? 8'hFF : 8'h00) || fall_b !== 8'h00)
        $display("FAIL all_rise cyc %0d got out=%h rise=%h fall=%h", i, out_b, rise_b, fall_b);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_a  = in_a ^ (4'($urandom) & 4'($urandom));
      in_b  = in_b ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      rst_a = ($urandom_range(0, 59) == 0);
      rst_b = ($urandom_range(0, 59) == 0);
      tick();
      n_total++;
      if ({out_a, rise_a, fall_a} !== {m_out[0][3:0], m_rise[0][3:0], m_fall[0][3:0]} || (rise_a & fall_a) !== 4'h0)
        $display("FAIL rand_a cyc %0d got %h/%h/%h want %h/%h/%h", i, out_a, rise_a, fall_a, m_out[0][3:0], m_rise[0][3:0], m_fall[0][3:0]);
      else n_pass++;
      n_total++;
      if ({out_b, rise_b, fall_b} !== {m_out[1], m_rise[1], m_fall[1]} || (rise_b & fall_b) !== 8'h00)
        $display("FAIL rand_b cyc %0d got %h/%h/%h want %h/%h/%h", i, out_b, rise_b, fall_b, m_out[1], m_rise[1], m_fall[1]);
      else n_pass++;
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; in_a = 4'h0; in_b = 8'h00;
    test_reset();
    test_latency();
    test_glitch();
    test_back_to_back();
    test_reset_mid_filter();
    test_all_rise();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
